// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg -- shared constants and types for the shift arbiter. Rev 1.0
`default_nettype none

package shift_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int CNT_W   = 16;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_arbiter_shift_unit.sv
// shift_unit -- combinational 32-bit sll/sra built from two 5-stage log shifters. Rev 1.0
`default_nettype none

module shift_unit
  import shift_arbiter_pkg::*;
(
  input  logic               i_op,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [DATA_W-1:0]  o_result
);

  logic [DATA_W-1:0] w_sll [0:SHAMT_W];
  logic [DATA_W-1:0] w_sra [0:SHAMT_W];

  assign w_sll[0] = i_data;
  assign w_sra[0] = i_data;

  // Stage s shifts by 2**s when shamt bit s is set.
  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign w_sll[s+1] = i_shamt[s] ? {w_sll[s][DATA_W-1-SH:0], {SH{1'b0}}} : w_sll[s];
    assign w_sra[s+1] = i_shamt[s] ? {{SH{w_sra[s][DATA_W-1]}}, w_sra[s][DATA_W-1:SH]} : w_sra[s];
  end

  assign o_result = (i_op == OP_SRA) ? w_sra[SHAMT_W] : w_sll[SHAMT_W];

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// shift_arbiter -- round-robin sharing of one shift unit with a registered single-slot output. Rev 1.0
`default_nettype none

module shift_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic               in0_op,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic [SHAMT_W-1:0] in0_shamt,
  input  logic               in1_valid,
  output logic               in1_ready,
  input  logic               in1_op,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic [SHAMT_W-1:0] in1_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_id,
  output logic [CNT_W-1:0]   op_count
);

  import shift_arbiter_pkg::*;

  slot_state_t        r_state;
  slot_state_t        w_state_nxt;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_id;
  logic               r_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_slot_free;
  logic               w_grant_vld;
  logic               w_grant_id;
  logic               w_accept;
  logic               w_sel_op;
  logic [DATA_W-1:0]  w_sel_data;
  logic [SHAMT_W-1:0] w_sel_shamt;
  logic [DATA_W-1:0]  w_result;

  assign out_valid   = (r_state == SLOT_FULL);
  assign w_slot_free = !out_valid || out_ready;

  // Pointer only breaks ties; a lone valid requester wins regardless.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = REQ0;
    if (w_slot_free) begin
      if (in0_valid && in1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = r_ptr;
      end else if (in0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = REQ0;
      end else if (in1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = REQ1;
      end
    end
  end

  assign in0_ready = w_grant_vld && (w_grant_id == REQ0);
  assign in1_ready = w_grant_vld && (w_grant_id == REQ1);
  assign w_accept  = w_grant_vld;

  always_comb begin
    w_sel_op    = in0_op;
    w_sel_data  = in0_data;
    w_sel_shamt = in0_shamt;
    if (w_grant_id == REQ1) begin
      w_sel_op    = in1_op;
      w_sel_data  = in1_data;
      w_sel_shamt = in1_shamt;
    end
  end

  shift_unit u_shift_unit (
    .i_op     (w_sel_op),
    .i_data   (w_sel_data),
    .i_shamt  (w_sel_shamt),
    .o_result (w_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = SLOT_FULL;
    end else if ((r_state == SLOT_FULL) && out_ready) begin
      w_state_nxt = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_data <= '0;
      r_out_id   <= REQ0;
      r_ptr      <= REQ0;
    end else if (w_accept) begin
      r_out_data <= w_result;
      r_out_id   <= w_grant_id;
      r_ptr      <= ~w_grant_id;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (out_valid && out_ready) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_data = r_out_data;
  assign out_id   = r_out_id;
  assign op_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter -- directed self-checking bench for shift_arbiter. Rev 1.0
`default_nettype none

module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        in0_valid, in0_ready, in0_op;
  logic [31:0] in0_data;
  logic [4:0]  in0_shamt;
  logic        in1_valid, in1_ready, in1_op;
  logic [31:0] in1_data;
  logic [4:0]  in1_shamt;
  logic        out_valid, out_ready, out_id;
  logic [31:0] out_data;
  logic [15:0] op_count;

  int n_vec  = 0;
  int n_fail = 0;

  shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_op    (in0_op),
    .in0_data  (in0_data),
    .in0_shamt (in0_shamt),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_op    (in1_op),
    .in1_data  (in1_data),
    .in1_shamt (in1_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in0_valid = 1'b0; in0_op = 1'b0; in0_data = '0; in0_shamt = '0;
    in1_valid = 1'b0; in1_op = 1'b0; in1_data = '0; in1_shamt = '0;
    out_ready = 1'b0;

    // Reset state
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_id",    {31'd0, out_id}, 32'd0);
    check("rst_count", {16'd0, op_count}, 32'd0);
    rst_n = 1'b1;

    // Single requester: sra 0x80000000 by 4
    in0_valid = 1'b1; in0_op = 1'b1; in0_data = 32'h8000_0000; in0_shamt = 5'd4;
    out_ready = 1'b1;
    #1;
    check("single_rdy0", {31'd0, in0_ready}, 32'd1);
    check("single_rdy1", {31'd0, in1_ready}, 32'd0);
    tick();
    in0_valid = 1'b0;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data",  out_data, 32'hF800_0000);
    check("single_id",    {31'd0, out_id}, 32'd0);
    check("single_cnt0",  {16'd0, op_count}, 32'd0);
    tick();
    check("single_cnt1",  {16'd0, op_count}, 32'd1);
    check("single_empty", {31'd0, out_valid}, 32'd0);

    // shamt=0 on both ops; pointer now favours requester 1
    in0_valid = 1'b1; in0_op = 1'b0; in0_data = 32'hA5A5_A5A5; in0_shamt = 5'd0;
    in1_valid = 1'b1; in1_op = 1'b1; in1_data = 32'hA5A5_A5A5; in1_shamt = 5'd0;
    #1;
    check("sh0_rdy1", {31'd0, in1_ready}, 32'd1);
    check("sh0_rdy0", {31'd0, in0_ready}, 32'd0);
    tick();
    in1_valid = 1'b0;
    check("sh0_sra_data", out_data, 32'hA5A5_A5A5);
    check("sh0_sra_id",   {31'd0, out_id}, 32'd1);
    tick();
    in0_valid = 1'b0;
    check("sh0_sll_data", out_data, 32'hA5A5_A5A5);
    check("sh0_sll_id",   {31'd0, out_id}, 32'd0);
    check("sh0_cnt",      {16'd0, op_count}, 32'd2);
    tick();
    check("sh0_cnt_end",  {16'd0, op_count}, 32'd3);

    // Reset mid-stream with a held result
    out_ready = 1'b0;
    in1_valid = 1'b1; in1_op = 1'b0; in1_data = 32'h1234_5678; in1_shamt = 5'd0;
    tick();
    in1_valid = 1'b0;
    check("mid_held_valid", {31'd0, out_valid}, 32'd1);
    check("mid_held_data",  out_data, 32'h1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data",  out_data, 32'd0);
    check("mid_rst_id",    {31'd0, out_id}, 32'd0);
    check("mid_rst_count", {16'd0, op_count}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Both valid continuously: ids alternate starting at requester 0
    in0_valid = 1'b1; in0_op = 1'b0; in0_data = 32'h0000_0001; in0_shamt = 5'd31;
    in1_valid = 1'b1; in1_op = 1'b1; in1_data = 32'h7FFF_FFFF; in1_shamt = 5'd31;
    out_ready = 1'b1;
    #1;
    check("alt_first_rdy0", {31'd0, in0_ready}, 32'd1);
    check("alt_first_rdy1", {31'd0, in1_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("alt_id",   {31'd0, out_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
      check("alt_data", out_data, (k % 2 == 0) ? 32'h8000_0000 : 32'h0000_0000);
    end
    check("alt_cnt", {16'd0, op_count}, 32'd3);

    // Backpressure for 3 cycles with both valid
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_rdy0", {31'd0, in0_ready}, 32'd0);
      check("bp_rdy1", {31'd0, in1_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_id",    {31'd0, out_id}, 32'd1);
      check("bp_data",  out_data, 32'h0000_0000);
      check("bp_cnt",   {16'd0, op_count}, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy0", {31'd0, in0_ready}, 32'd1);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    check("bp_nobubble_valid", {31'd0, out_valid}, 32'd1);
    check("bp_nobubble_id",    {31'd0, out_id}, 32'd0);
    check("bp_nobubble_data",  out_data, 32'h8000_0000);
    check("bp_nobubble_cnt",   {16'd0, op_count}, 32'd4);
    tick();
    check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    check("bp_drain_cnt",   {16'd0, op_count}, 32'd5);

    // Counter wrap: 65536 consumed results from a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    in0_valid = 1'b1; in0_op = 1'b0; in0_data = 32'h0000_0003; in0_shamt = 5'd1;
    out_ready = 1'b1;
    tick();
    check("wrap_first_data", out_data, 32'h0000_0006);
    for (int k = 2; k <= 65536; k++) begin
      tick();
    end
    check("wrap_ffff", {16'd0, op_count}, 32'h0000_FFFF);
    in0_valid = 1'b0;
    tick();
    check("wrap_zero",  {16'd0, op_count}, 32'h0000_0000);
    check("wrap_empty", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational shift unit (logical left / arithmetic right, 32-bit, 5-bit shamt) between two requesters in the ALU/execute path.
- Round-robin arbitration on valid/ready inputs.
- Registered single-slot output with backpressure, so an accepted operation completes one cycle later.
- Counts completed operations.

Parameters:
- DATA_W, 32, operand/result width; fixed at 32 (shift unit is 32-bit).
- SHAMT_W, 5, shift amount width; must equal log2(DATA_W).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in0_valid  input  1  requester 0 has an operation.
- in0_ready  output  1  requester 0 operation accepted this cycle.
- in0_op  input  1  0 = sll, 1 = sra.
- in0_data  input  DATA_W  operand.
- in0_shamt  input  SHAMT_W  shift amount.
- in1_valid, in1_ready, in1_op, in1_data, in1_shamt: same as requester 0.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer takes result.
- out_data  output  DATA_W  shifted result.
- out_id  output  1  requester that issued the result.
- op_count  output  CNT_W  results consumed since reset.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - out_valid=0, out_data=0, out_id=0, op_count=0.
  - Priority pointer = requester 0.
- Any held result is discarded on reset. Outputs hold these values until the first clock edge after reset is released.
- Output slot states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- slot_free = !out_valid | out_ready (combinational).
- Grant (combinational), evaluated only when slot_free:
  - Only one valid: grant it.
  - Both valid: grant the requester named by the priority pointer.
  - Neither valid: no grant.
- inX_ready = slot_free & grant==X. At most one ready is high per cycle. A combinational valid->ready path is permitted.
- An operation is accepted when inX_valid & inX_ready. On that edge:
  - out_data <= shift_unit(inX_op, inX_data, inX_shamt).
  - out_id <= X.
  - out_valid <= 1.
  - Priority pointer <= the other requester.
- Latency: acceptance at edge N gives out_valid high after edge N.
- Throughput: one result per cycle while out_ready stays high.
- Pointer changes only on acceptance. A requester held valid is accepted within 2 accepting cycles (no starvation).
- FULL with out_ready=0:
  - out_* hold stable.
  - Both in*_ready=0.
- FULL with out_ready=1 and no grant: out_valid <= 0 (EMPTY).
- FULL with out_ready=1 and a grant: the new result replaces the old one in the same edge, with no bubble.
- op_count increments by 1 on each out_valid & out_ready edge and wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
- Shift arithmetic:
  - shamt=0 passes data through unchanged.
  - sll fills 0s.
  - sra replicates data[31] into vacated bits.
  - shamt=31 gives all-0 (sll, except bit 31 = data[0]) or all-sign (sra).
- Inputs of a non-accepted requester are ignored; the requester must hold them stable until ready.

Decomposition:
- Shared package holds:
  - Opcode constants OP_SLL=1'b0, OP_SRA=1'b1.
  - DATA_W=32, SHAMT_W=5.
  - Requester ids REQ0=0, REQ1=1.
- One sub-module, shift_unit: purely combinational; op, data, shamt -> result. Built from a 5-stage log shifter for sll and one for sra, with a final 2:1 select on op.
- shift_arbiter contains grant logic, priority pointer, output register and counter.

Test Plan:
- Reset mid-stream: assert reset (low) while out_valid=1 -> out_valid=0, op_count=0 immediately without a clock; after release, first grant with both valid goes to requester 0.
- Single requester: in0 sra, data=0x80000000, shamt=4, out_ready=1 -> in0_ready=1 that cycle; next cycle out_valid=1, out_data=0xF8000000, out_id=0, op_count=1 after consume.
- Both valid continuously, out_ready=1, in0 sll 0x00000001 shamt=31, in1 sra 0x7FFFFFFF shamt=31 -> ids alternate 0,1,0,1; data alternates 0x80000000, 0x00000000.
- Backpressure: out_ready=0 for 3 cycles with result held, both inputs valid -> out_data/out_id stable, in0_ready=in1_ready=0; out_ready=1 -> next result loaded same edge as consume, no bubble.
- shamt=0 both ops on 0xA5A5A5A5 -> result 0xA5A5A5A5.
- Counter wrap: force 65536 consumed results -> op_count returns to 0x0000.
